// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision add/sub datapath.
// Contents: IEEE-754 field widths, bias and quiet-NaN constant, FSM state type,
// field-split record and helper.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned BIAS   = 127;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StPack,
        StDone
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_fields_t;

    function automatic fp_fields_t fp_split(input logic [31:0] v);
        fp_fields_t f;
        f.sign = v[31];
        f.exp  = v[30:23];
        f.frac = v[22:0];
        return f;
    endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand-pair / result handshake bundle for the sequential add/sub unit.
// master: drives in_valid, para1, para2, op, out_ready; observes in_ready and results.
// slave : the execution unit (drives in_ready, out_valid, out, under_overflow).
interface fp_addsub_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] para1;
    logic [31:0] para2;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        under_overflow;

    modport master (
        output in_valid, para1, para2, op, out_ready,
        input  in_ready, out_valid, out, under_overflow
    );

    modport slave (
        input  in_valid, para1, para2, op, out_ready,
        output in_ready, out_valid, out, under_overflow
    );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter (priority encoder on the highest set bit).
// value_i : vector to scan, MSB first
// count_o : number of zeros above the highest set bit; WIDTH when value_i is zero
module fp_lzc #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CNT_W-1:0] count_o
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract, round toward zero.
// clk, rst : clock and synchronous active-high reset
// bus_io   : slave side of fp_addsub_seq_if (operand pair in, result + exception flag out)
// One pair in flight: IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int unsigned GUARD_BITS   = 3,
    parameter bit          FLUSH_DENORM = 1'b1
) (
    input logic            clk,
    input logic            rst,
    fp_addsub_seq_if.slave bus_io
);

    localparam int unsigned MAN_W = FRAC_W + 1 + GUARD_BITS;
    localparam int unsigned SUM_W = MAN_W + 1;
    localparam int unsigned CNT_W = $clog2(MAN_W + 1);

    state_e           state_q, state_d;
    logic             accept;
    logic [31:0]      a_q, b_q;
    logic             special_q, sign_q, eff_sub_q, zero_q;
    logic [9:0]       exp_q;  // two's complement; bit 9 set means below zero
    logic [MAN_W-1:0] man_l_q, man_s_q, norm_man_q;
    logic [SUM_W-1:0] sum_q;
    logic [31:0]      out_q;
    logic             uo_q;

    fp_fields_t       fa, fb;
    logic             a_zero, b_zero, swap;
    logic [EXP_W-1:0] ea, eb, exp_l, exp_s, exp_diff;
    logic [MAN_W-1:0] man_a, man_b, man_sel_s, man_s_shift;
    logic [CNT_W-1:0] lzc_cnt;
    logic [31:0]      pack_out;
    logic             pack_uo;
    logic             unused_man;

    assign accept = bus_io.in_valid && bus_io.in_ready;

    always_comb begin
        bus_io.in_ready       = (state_q == StIdle) && !rst;
        bus_io.out_valid      = (state_q == StDone);
        bus_io.out            = out_q;
        bus_io.under_overflow = uo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = StPack;
            StPack:  state_d = StDone;
            StDone:  if (bus_io.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Alignment: exponent-0 operands become zeros when flushing; otherwise they take
    // effective exponent 1 with no hidden bit.
    always_comb begin
        fa          = fp_split(a_q);
        fb          = fp_split(b_q);
        a_zero      = FLUSH_DENORM && (fa.exp == '0);
        b_zero      = FLUSH_DENORM && (fb.exp == '0);
        ea          = (fa.exp == '0) ? EXP_W'(1) : fa.exp;
        eb          = (fb.exp == '0) ? EXP_W'(1) : fb.exp;
        man_a       = a_zero ? '0 : {fa.exp != '0, fa.frac, {GUARD_BITS{1'b0}}};
        man_b       = b_zero ? '0 : {fb.exp != '0, fb.frac, {GUARD_BITS{1'b0}}};
        // Exponent:fraction ordering equals magnitude ordering.
        swap        = (b_zero ? 31'b0 : b_q[30:0]) > (a_zero ? 31'b0 : a_q[30:0]);
        exp_l       = swap ? eb : ea;
        exp_s       = swap ? ea : eb;
        man_sel_s   = swap ? man_a : man_b;
        exp_diff    = exp_l - exp_s;
        man_s_shift = ({24'b0, exp_diff} >= MAN_W) ? '0 : (man_sel_s >> exp_diff);
    end

    fp_lzc #(
        .WIDTH(MAN_W),
        .CNT_W(CNT_W)
    ) u_lzc (
        .value_i(sum_q[MAN_W-1:0]),
        .count_o(lzc_cnt)
    );

    always_comb begin
        pack_uo  = 1'b0;
        pack_out = {sign_q, exp_q[7:0], norm_man_q[MAN_W-2 -: FRAC_W]};
        if (special_q) begin
            pack_out = QNAN;
            pack_uo  = 1'b1;
        end else if (zero_q) begin
            // Exact cancellation is +0; only -0 + -0 keeps the sign.
            pack_out = {sign_q & ~eff_sub_q, 31'b0};
        end else if (!exp_q[9] && (exp_q >= 10'(2 * BIAS + 1))) begin
            pack_out = {sign_q, 8'hFF, 23'b0};
            pack_uo  = 1'b1;
        end else if (exp_q[9] || (exp_q == '0)) begin
            pack_out = {sign_q, 31'b0};
            pack_uo  = 1'b1;
        end
    end

    // Hidden bit and guard bits are dropped at pack (truncation).
    assign unused_man = ^{norm_man_q[MAN_W-1], norm_man_q[GUARD_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            special_q  <= 1'b0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            zero_q     <= 1'b0;
            exp_q      <= '0;
            man_l_q    <= '0;
            man_s_q    <= '0;
            norm_man_q <= '0;
            sum_q      <= '0;
            out_q      <= '0;
            uo_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q <= bus_io.para1;
                        b_q <= {bus_io.para2[31] ^ bus_io.op, bus_io.para2[30:0]};
                    end
                end
                StAlign: begin
                    special_q <= (fa.exp == 8'hFF) || (fb.exp == 8'hFF);
                    sign_q    <= swap ? fb.sign : fa.sign;
                    eff_sub_q <= fa.sign ^ fb.sign;
                    exp_q     <= {2'b00, exp_l};
                    man_l_q   <= swap ? man_b : man_a;
                    man_s_q   <= man_s_shift;
                end
                StAdd: begin
                    sum_q <= eff_sub_q ? ({1'b0, man_l_q} - {1'b0, man_s_q})
                                       : ({1'b0, man_l_q} + {1'b0, man_s_q});
                end
                StNorm: begin
                    zero_q <= (sum_q == '0);
                    if (sum_q[SUM_W-1]) begin
                        norm_man_q <= sum_q[SUM_W-1:1];
                        exp_q      <= exp_q + 10'd1;
                    end else begin
                        norm_man_q <= sum_q[MAN_W-1:0] << lzc_cnt;
                        exp_q      <= exp_q - {{(10 - CNT_W){1'b0}}, lzc_cnt};
                    end
                end
                StPack: begin
                    out_q <= pack_out;
                    uo_q  <= pack_uo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: the driver pushes expected results on each
// accepted pair; a negedge monitor compares whenever the unit presents a result.
module tb_fp_addsub_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_seq_if bus ();

    fp_addsub_seq #(
        .GUARD_BITS(3),
        .FLUSH_DENORM(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_io(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit bp_rand = 1'b0;
    bit prev_v = 1'b0;
    logic [32:0] exp_q[$];  // {flag, result}
    int acc_q[$];           // cycle of each handshake

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level add of two singles, B mantissa aligned with 3 guard bits,
    // shifted-out bits lost, result truncated toward zero.
    function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b_in,
                                              input logic op);
        logic [31:0] b;
        int ea, eb, el, es, d, e;
        longint ma, mb, ml, ms, s;
        logic sa, sb, sl;
        bit same;
        b = {b_in[31] ^ op, b_in[30:0]};
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b1, 32'h7FC0_0000};
        ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]}) * 8;
        mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]}) * 8;
        sa = a[31];
        sb = b[31];
        if (eb > ea || (eb == ea && mb > ma)) begin
            el = eb; ml = mb; sl = sb; es = ea; ms = ma;
        end else begin
            el = ea; ml = ma; sl = sa; es = eb; ms = mb;
        end
        d = el - es;
        ms = (d >= 27) ? 64'sd0 : (ms >> d);
        same = (sa == sb);
        s = same ? ml + ms : ml - ms;
        if (s == 0) return {1'b0, same ? sl : 1'b0, 31'b0};
        e = el;
        while (s >= 64'sd134217728) begin s = s >> 1; e++; end
        while (s < 64'sd67108864) begin s = s << 1; e--; end
        if (e >= 255) return {1'b1, sl, 8'hFF, 23'b0};
        if (e <= 0) return {1'b1, sl, 31'b0};
        return {1'b0, sl, e[7:0], s[25:3]};
    endfunction

    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b, output logic o);
        int k;
        k = $urandom_range(0, 9);
        a = $urandom;
        b = $urandom;
        o = 1'($urandom_range(0, 1));
        case (k)
            0, 1, 2, 3: b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
            4: b[30:0] = a[30:0];
            5: begin
                a[30:23] = 8'hFE - 8'($urandom_range(0, 1));
                b[30:23] = 8'hFE - 8'($urandom_range(0, 2));
            end
            6: begin
                a[30:23] = 8'($urandom_range(1, 3));
                b[30:23] = a[30:23];
                b[22:0] = a[22:0] ^ 23'($urandom_range(0, 255));
            end
            7: if ($urandom_range(0, 1) == 1) a[30:23] = 8'h00; else b[30:23] = 8'h00;
            8: if ($urandom_range(0, 1) == 1) a[30:23] = 8'hFF; else b[30:23] = 8'hFF;
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] eo, input logic ef);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.para1 = a;
        bus.para2 = b;
        bus.op = o;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: actual=in_ready low for %0d cycles required=accept", n);
        end else begin
            exp_q.push_back({ef, eo});
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.para1 = $urandom;  // later input changes must not matter
        bus.para2 = $urandom;
        bus.op = ~bus.op;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.in_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: actual=%0d results pending required=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL latency: actual=out_valid with no accepted pair required=none");
                end else begin
                    check("latency", 32'(cyc - acc_q.pop_front()), 32'd5);
                end
            end
            if (bus.out_valid) begin
                check("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: actual=%h required=no result", bus.out);
                end else begin
                    check("result", bus.out, exp_q[0][31:0]);
                    check("flag", {31'b0, bus.under_overflow}, {31'b0, exp_q[0][32]});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_v = bus.out_valid;
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic ro;
        logic [32:0] r;
        int n;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.para1 = '0;
        bus.para2 = '0;
        bus.op = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out", bus.out, 32'h0);
        check("rst_flag", {31'b0, bus.under_overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Directed cases
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0); wait_drain();
        send(32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 1'b0); wait_drain();
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0); wait_drain();
        send(32'hC040_0000, 32'h3F80_0000, 1'b0, 32'hC000_0000, 1'b0); wait_drain();
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1); wait_drain();
        send(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1); wait_drain();
        send(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0); wait_drain();
        send(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0); wait_drain();
        send(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b1); wait_drain();

        // Back-pressure: result held for 7 cycles with a second pair waiting
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 1'b0);
        fork
            send(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0);
        join_none
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", {31'b0, bus.out_valid}, 32'd1);
        repeat (7) @(negedge clk);
        check("bp_one_pending", 32'(exp_q.size()), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset while the pair sits in NORM
        send(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
        wait_drain();

        // Randomized against the reference model, random back-pressure
        bp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            gen_pair(ra, rb, ro);
            r = ref_model(ra, rb, ro);
            send(ra, rb, ro, r[31:0], r[32]);
        end
        bp_rand = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
